turfio_cin_lock: RTL and testbench
==================================

// Module: turfio_cin_lock
// PURPOSE
//  ACLK-domain consumer of the CIN nibble stream from the RXCLK->ACLK transfer (data + ce).
//  Hunts for the 32-bit training word, finds the nibble phase of the word boundary and confirms lock.
//  Once locked, assembles 32-bit command words for downstream command decode.
//  Serves the register core's lock_rst/lock_req/lock_status/cin_err controls.
// PARAMETERS
//  TRAIN_PATTERN   32'hA55A6996  training word, first nibble received = bits [31:28]
//  LOCK_COUNT      4             consecutive aligned training words to declare lock (range 1..15)
//  HUNT_TIMEOUT    4096          data_ce_i count in HUNT before abort (range 8..65535)
// PORTS
//  aclk_i          in   1   ACLK, sole clock
//  aclk_rstn_i     in   1   async active-low reset
//  lock_rst_i      in   1   sync reset of lock FSM (level)
//  lock_req_i      in   1   1-cycle pulse: start/restart hunt
//  train_en_i      in   1   high = link in training, words checked not forwarded
//  data_i          in   4   CIN nibble, qualified by data_ce_i
//  data_ce_i       in   1   nibble valid
//  lock_status_o   out  1   high while LOCKED
//  cin_err_o       out  1   1-cycle error pulse
//  cmd_o           out  32  assembled command word
//  cmd_valid_o     out  1   1-cycle strobe, cmd_o valid
//  err_count_o     out  16  saturating error count (only with TURFIO_CIN_ERRCNT_EN)
// BEHAVIOUR
//  Reset (async, aclk_rstn_i=0): state IDLE; all outputs 0; shift reg, nibble/match/timeout counters 0.
//  Shift: on data_ce_i, sr <= {sr[27:0],data_i}; inputs with data_ce_i=0 are ignored in every state.
//  States (enum in package): IDLE, HUNT, CONFIRM, LOCKED.
//  IDLE: waits; lock_req_i -> HUNT, timeout ctr cleared.
//  HUNT: each ce, compare new sr value to TRAIN_PATTERN. Match -> CONFIRM, nib_cnt<=0, match_cnt<=1.
//    No match -> timeout ctr++; when it reaches HUNT_TIMEOUT -> IDLE + cin_err_o pulse.
//  Boundary: in CONFIRM/LOCKED, nib_cnt counts 0..7 mod 8 on ce; the ce with nib_cnt==7 completes a word.
//  CONFIRM: at boundary, word==pattern -> match_cnt++; on reaching LOCK_COUNT -> LOCKED.
//    Mismatch -> HUNT, match_cnt<=0, timeout ctr<=0 (no error pulse).
//    LOCK_COUNT=1: lock is declared on the initial HUNT match; CONFIRM is skipped.
//  LOCKED: lock_status_o=1, registered, asserted the cycle after the confirming ce.
//    At boundary, if !train_en_i: cmd_o<=word, cmd_valid_o=1 for one cycle, 1 aclk after the completing ce.
//    If train_en_i and word!=pattern: cin_err_o pulse (cmd not emitted); lock held.
//    cmd_o holds its last value between strobes.
//  Priority: lock_rst_i > lock_req_i > FSM transitions.
//    lock_rst_i: IDLE, lock_status_o=0, counters 0, no pulses; sr is kept.
//    lock_req_i in any state: HUNT with counters cleared; lock_status_o drops the next cycle.
//  Reset mid-word or mid-hunt discards the partial word; no cmd_valid_o is generated for it.
//  Timeout ctr is 16 bits wide and never wraps (saturates at HUNT_TIMEOUT, then exits HUNT).
// CONFIGURATION
//  `TURFIO_CIN_ERRCNT_EN defined:
//    err_count_o increments on every cin_err_o pulse and saturates at 16'hFFFF.
//    Cleared by aclk_rstn_i or lock_rst_i, not by lock_req_i.
//  Not defined: port err_count_o absent; no counter logic; all other behaviour identical.
// STRUCTURE
//  Package turfio_cin_pkg:
//    cin_lock_state_t enum (IDLE/HUNT/CONFIRM/LOCKED); TRAIN_PATTERN_DEFAULT = 32'hA55A6996;
//    CIN_NIBBLES_PER_WORD = 8.
//  Sub-module turfio_cin_word_assembler:
//    nibble shift reg + mod-8 nibble counter + word-complete strobe; counter realigned by a sync_i input.
//  Top module: FSM, match/timeout counters, output registers, optional error counter.
// TESTING
//  1 Reset, lock_req, pattern nibbles A,5,5,A,6,9,9,6 repeated (ce every 3rd aclk) -> LOCKED after
//    4 words; lock_status_o=1 one aclk after the 32nd nibble.
//  2 Random 3-nibble prefix then pattern -> alignment found; LOCKED;
//    train_en=0, send 32'h12345678 -> cmd_valid_o pulse, cmd_o=32'h12345678, 1 aclk after its last ce.
//  3 During CONFIRM, corrupt one nibble of word 3 -> back to HUNT, no cin_err_o;
//    pattern resumed -> lock after 4 more good words.
//  4 HUNT with constant 4'h0 nibbles -> cin_err_o pulse on the 4096th ce; state IDLE; lock_status_o=0.
//  5 LOCKED, train_en=1, one word 32'hA55A6997 -> one cin_err_o, no cmd_valid_o, lock held;
//    with ERRCNT_EN err_count_o=1.
//  6 LOCKED: assert lock_rst_i and lock_req_i together -> IDLE, lock_status_o=0;
//    separately, aclk_rstn_i low mid-word -> all outputs 0 immediately.

Source files
------------

// File: rtl/turfio_cin_pkg.sv
// turfio_cin_pkg: shared state type and constants for the CIN lock block.
package turfio_cin_pkg;
   typedef enum logic [1:0] {IDLE, HUNT, CONFIRM, LOCKED} cin_lock_state_t;
   localparam logic [31:0] TRAIN_PATTERN_DEFAULT = 32'hA55A6996;
   localparam int CIN_NIBBLES_PER_WORD = 8;
endpackage

// File: rtl/turfio_cin_lock_if.sv
// turfio_cin_lock_if: CIN nibble stream in, assembled command words out.
interface turfio_cin_lock_if;
   logic [3:0]  data;
   logic        data_ce;
   logic [31:0] cmd;
   logic        cmd_valid;
   modport master (output data, data_ce, input cmd, cmd_valid);
   modport slave  (input data, data_ce, output cmd, cmd_valid);
endinterface

// File: rtl/turfio_cin_word_assembler.sv
// turfio_cin_word_assembler: nibble shift register plus mod-8 word phase counter.
// sync_i forces the phase to 0 so the following 8 nibbles form one word.
module turfio_cin_word_assembler
   import turfio_cin_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  data_i,
   input  logic        ce_i,
   input  logic        sync_i,
   output logic [31:0] word_o,
   output logic        done_o
);
   localparam logic [2:0] LAST_NIB = 3'(CIN_NIBBLES_PER_WORD - 1);
   logic [31:0] sr_q, sr_d;
   logic [2:0]  nib_q, nib_d;
   always_comb begin
      word_o = {sr_q[27:0], data_i};
      sr_d   = ce_i ? word_o : sr_q;
      nib_d  = sync_i ? 3'd0 : ce_i ? nib_q + 3'd1 : nib_q;
      done_o = ce_i && !sync_i && nib_q == LAST_NIB;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sr_q  <= '0;
         nib_q <= '0;
      end else begin
         sr_q  <= sr_d;
         nib_q <= nib_d;
      end
endmodule

// File: rtl/turfio_cin_lock.sv
// turfio_cin_lock: hunts for the CIN training word, confirms lock, then forwards command words.
// Define TURFIO_CIN_ERRCNT_EN to add the saturating err_count_o error counter.
module turfio_cin_lock
   import turfio_cin_pkg::*;
#(
   parameter logic [31:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned HUNT_TIMEOUT  = 4096
) (
   input  logic               aclk_i,
   input  logic               aclk_rstn_i,
   input  logic               lock_rst_i,
   input  logic               lock_req_i,
   input  logic               train_en_i,
   turfio_cin_lock_if.slave   cin,
   output logic               lock_status_o,
   output logic               cin_err_o
`ifdef TURFIO_CIN_ERRCNT_EN
  ,output logic [15:0]        err_count_o
`endif
);
   localparam logic [3:0]  LOCK_N = LOCK_COUNT[3:0];
   localparam logic [15:0] TMO_N  = HUNT_TIMEOUT[15:0];
   cin_lock_state_t state_q, state_d;
   logic [3:0]  match_q, match_d;
   logic [15:0] tmo_q, tmo_d;
   logic [31:0] cmd_q, cmd_d, word;
   logic        cmd_valid_q, cmd_valid_d, status_q, status_d, err_q, err_d;
   logic        done, hit, sync;
   assign hit  = cin.data_ce && word == TRAIN_PATTERN;
   // the hunt match fixes the word boundary: the next nibble starts a word
   assign sync = lock_rst_i || lock_req_i || (state_q == HUNT && hit);
   turfio_cin_word_assembler u_asm (
      .clk(aclk_i), .rst_n(aclk_rstn_i), .data_i(cin.data), .ce_i(cin.data_ce),
      .sync_i(sync), .word_o(word), .done_o(done)
   );
   always_comb begin
      state_d     = state_q;
      match_d     = match_q;
      tmo_d       = tmo_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      err_d       = 1'b0;
      if (lock_rst_i || lock_req_i) begin
         state_d = lock_rst_i ? IDLE : HUNT;
         match_d = '0;
         tmo_d   = '0;
      end else begin
         case (state_q)
            HUNT: if (hit) begin
               state_d = LOCK_N == 4'd1 ? LOCKED : CONFIRM;
               match_d = 4'd1;
            end else if (cin.data_ce) begin
               tmo_d = tmo_q + 16'd1;
               if (tmo_d == TMO_N) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
            CONFIRM: if (done) begin
               if (word == TRAIN_PATTERN) begin
                  match_d = match_q + 4'd1;
                  if (match_d == LOCK_N) state_d = LOCKED;
               end else begin
                  state_d = HUNT;
                  match_d = '0;
                  tmo_d   = '0;
               end
            end
            LOCKED: if (done) begin
               cmd_valid_d = !train_en_i;
               cmd_d       = train_en_i ? cmd_q : word;
               err_d       = train_en_i && word != TRAIN_PATTERN;
            end
            default: ;
         endcase
      end
      status_d = state_d == LOCKED;
   end
   always_ff @(posedge aclk_i or negedge aclk_rstn_i)
      if (!aclk_rstn_i) begin
         state_q     <= IDLE;
         match_q     <= '0;
         tmo_q       <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         status_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         match_q     <= match_d;
         tmo_q       <= tmo_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         status_q    <= status_d;
         err_q       <= err_d;
      end
   assign cin.cmd       = cmd_q;
   assign cin.cmd_valid = cmd_valid_q;
   assign lock_status_o = status_q;
   assign cin_err_o     = err_q;
`ifdef TURFIO_CIN_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   always_comb err_cnt_d = lock_rst_i ? '0 : (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
   always_ff @(posedge aclk_i or negedge aclk_rstn_i)
      if (!aclk_rstn_i) err_cnt_q <= '0;
      else err_cnt_q <= err_cnt_d;
   assign err_count_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_turfio_cin_lock.sv
// tb_turfio_cin_lock: table vectors, directed corner sequences and random traffic
// against a nibble-history reference model of the CIN lock block.
module tb_turfio_cin_lock;
   localparam logic [31:0] PAT = 32'hA55A6996;
   localparam int LOCKN = 4;
   localparam int TMO = 4096;
   localparam int M_IDLE = 0, M_HUNT = 1, M_CONF = 2, M_LOCK = 3;
   logic clk = 1'b0, rstn = 1'b0, lrst = 1'b0, lreq = 1'b0, train = 1'b1;
   logic st, err;
`ifdef TURFIO_CIN_ERRCNT_EN
   logic [15:0] err_count;
`endif
   turfio_cin_lock_if cin();
   turfio_cin_lock dut (
      .aclk_i(clk), .aclk_rstn_i(rstn), .lock_rst_i(lrst), .lock_req_i(lreq),
      .train_en_i(train), .cin(cin), .lock_status_o(st), .cin_err_o(err)
`ifdef TURFIO_CIN_ERRCNT_EN
     ,.err_count_o(err_count)
`endif
   );
   always #5 clk = ~clk;

   int total = 0, bad = 0, n_err = 0, n_cv = 0;
   int m_mode, m_matches, m_tmo, m_since, m_errs;
   logic [3:0]  hist[$];
   logic [31:0] m_cmd;
   logic        m_cv, m_err;

   function automatic logic [31:0] hist_word();
      logic [31:0] w = '0;
      foreach (hist[i]) w = (w << 4) | 32'(hist[i]);
      return w;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_matches = 0; m_tmo = 0; m_since = 0; m_errs = 0;
      m_cmd = '0; m_cv = 1'b0; m_err = 1'b0;
      hist = {};
      repeat (8) hist.push_back(4'h0);
   endtask

   // one aclk of the reference: the last 8 received nibbles form the candidate word,
   // and the word boundary falls every 8th nibble after the hunt match
   task automatic model_clock(input logic r, q, t, c, input logic [3:0] d);
      logic [31:0] w;
      m_cv = 1'b0; m_err = 1'b0;
      if (c) begin
         hist.push_back(d);
         void'(hist.pop_front());
      end
      w = hist_word();
      if (r) begin
         m_mode = M_IDLE; m_matches = 0; m_tmo = 0; m_errs = 0;
      end else if (q) begin
         m_mode = M_HUNT; m_matches = 0; m_tmo = 0;
      end else if (c) begin
         m_since++;
         if (m_mode == M_HUNT) begin
            if (w == PAT) begin
               m_since = 0; m_matches = 1;
               m_mode = (LOCKN == 1) ? M_LOCK : M_CONF;
            end else begin
               m_tmo++;
               if (m_tmo == TMO) begin m_mode = M_IDLE; m_err = 1'b1; end
            end
         end else if ((m_mode == M_CONF || m_mode == M_LOCK) && m_since % 8 == 0) begin
            if (m_mode == M_CONF) begin
               if (w == PAT) begin
                  m_matches++;
                  if (m_matches == LOCKN) m_mode = M_LOCK;
               end else begin
                  m_mode = M_HUNT; m_matches = 0; m_tmo = 0;
               end
            end else if (!t) begin
               m_cmd = w; m_cv = 1'b1;
            end else if (w != PAT) m_err = 1'b1;
         end
      end
      if (m_err && m_errs < 65535) m_errs++;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic ok;
      ok = st === (m_mode == M_LOCK) && err === m_err && cin.cmd_valid === m_cv && cin.cmd === m_cmd;
`ifdef TURFIO_CIN_ERRCNT_EN
      ok = ok && err_count === 16'(m_errs);
`endif
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL cyc t=%0t dut st=%b err=%b cv=%b cmd=%h model st=%b err=%b cv=%b cmd=%h",
                  $time, st, err, cin.cmd_valid, cin.cmd, m_mode == M_LOCK, m_err, m_cv, m_cmd);
      end
   endtask

   task automatic step(input logic r, q, t, c, input logic [3:0] d);
      @(negedge clk);
      lrst = r; lreq = q; train = t; cin.data_ce = c; cin.data = d;
      @(posedge clk);
      if (rstn) model_clock(r, q, t, c, d);
      else model_reset();
      #1 check_outputs();
      n_err += int'(err);
      n_cv  += int'(cin.cmd_valid);
   endtask

   task automatic send_nib(input logic t, input logic [3:0] d);
      step(1'b0, 1'b0, t, 1'b0, 4'h0);
      step(1'b0, 1'b0, t, 1'b0, 4'h0);
      step(1'b0, 1'b0, t, 1'b1, d);
   endtask

   task automatic send_word(input logic t, input logic [31:0] w);
      for (int i = 0; i < 8; i++) send_nib(t, w[31 - 4*i -: 4]);
   endtask

   typedef struct {
      logic        train;
      logic [31:0] word;
      logic        st;
      int          errs;
      int          cvs;
      logic [31:0] cmd;
   } vec_t;
   vec_t vec[9];

   initial begin
      logic [31:0] blk, pw;
      int pidx;
      logic c, r, q, t;
      logic [3:0] d;
      vec[0] = '{1'b1, PAT,          1'b0, 0, 0, 32'h0};
      vec[1] = '{1'b1, PAT,          1'b0, 0, 0, 32'h0};
      vec[2] = '{1'b1, PAT,          1'b0, 0, 0, 32'h0};
      vec[3] = '{1'b1, PAT,          1'b1, 0, 0, 32'h0};
      vec[4] = '{1'b0, 32'h12345678, 1'b1, 0, 1, 32'h12345678};
      vec[5] = '{1'b1, 32'hA55A6997, 1'b1, 1, 0, 32'h12345678};
      vec[6] = '{1'b1, PAT,          1'b1, 0, 0, 32'h12345678};
      vec[7] = '{1'b0, 32'hDEADBEEF, 1'b1, 0, 1, 32'hDEADBEEF};
      vec[8] = '{1'b0, PAT,          1'b1, 0, 1, PAT};
      cin.data = '0; cin.data_ce = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_status", 32'(st), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_cv", 32'(cin.cmd_valid), 0);
      chk("rst_cmd", cin.cmd, 0);
      @(negedge clk) rstn = 1'b1;

      // test 1 and 5: table of whole words, ce every third aclk
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 9; i++) begin
         n_err = 0; n_cv = 0;
         send_word(vec[i].train, vec[i].word);
         chk($sformatf("vec%0d_status", i), 32'(st), 32'(vec[i].st));
         chk($sformatf("vec%0d_errs", i), 32'(n_err), 32'(vec[i].errs));
         chk($sformatf("vec%0d_cvs", i), 32'(n_cv), 32'(vec[i].cvs));
         chk($sformatf("vec%0d_cmd", i), cin.cmd, vec[i].cmd);
      end
`ifdef TURFIO_CIN_ERRCNT_EN
      chk("errcnt_one", 32'(err_count), 1);
`endif

      // test 2: random 3-nibble prefix, then alignment and a command word
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      repeat (3) send_nib(1'b1, 4'($urandom));
      repeat (LOCKN) send_word(1'b1, PAT);
      chk("t2_lock", 32'(st), 1);
      n_cv = 0;
      send_word(1'b0, 32'h12345678);
      chk("t2_cv_timing", 32'(cin.cmd_valid), 1);
      chk("t2_cv_count", 32'(n_cv), 1);
      chk("t2_cmd", cin.cmd, 32'h12345678);

      // test 3: corrupted word during confirm drops back to hunt silently
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      n_err = 0;
      repeat (2) send_word(1'b1, PAT);
      send_word(1'b1, PAT ^ 32'h00F00000);
      repeat (3) send_word(1'b1, PAT);
      chk("t3_not_yet", 32'(st), 0);
      send_word(1'b1, PAT);
      chk("t3_relock", 32'(st), 1);
      chk("t3_no_err", 32'(n_err), 0);

      // test 4: hunt timeout on constant zero nibbles
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("t4_req_drop", 32'(st), 0);
      n_err = 0;
      repeat (TMO - 1) step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
      chk("t4_no_early_err", 32'(n_err), 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
      chk("t4_err_pulse", 32'(err), 1);
      chk("t4_status", 32'(st), 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
      chk("t4_single_pulse", 32'(err), 0);
      repeat (LOCKN) send_word(1'b1, PAT);
      chk("t4_idle", 32'(st), 0);

      // test 6: lock_rst with lock_req, then async reset mid-word
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      repeat (LOCKN) send_word(1'b1, PAT);
      chk("t6_locked", 32'(st), 1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("t6_rst_req", 32'(st), 0);
`ifdef TURFIO_CIN_ERRCNT_EN
      chk("t6_errcnt_clr", 32'(err_count), 0);
`endif
      repeat (2) send_word(1'b1, PAT);
      chk("t6_idle", 32'(st), 0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      repeat (LOCKN) send_word(1'b1, PAT);
      send_word(1'b0, 32'hCAFEF00D);
      for (int i = 0; i < 5; i++) send_nib(1'b0, 4'(i));
      #2 rstn = 1'b0;
      #1;
      chk("t6_async_status", 32'(st), 0);
      chk("t6_async_err", 32'(err), 0);
      chk("t6_async_cv", 32'(cin.cmd_valid), 0);
      chk("t6_async_cmd", cin.cmd, 0);
      model_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
      @(negedge clk) rstn = 1'b1;
      n_cv = 0;
      for (int i = 5; i < 8; i++) send_nib(1'b0, 4'(i));
      chk("t6_no_partial_cmd", 32'(n_cv), 0);

      // random traffic: mostly training words, some commands, slips and control pulses
      pw = PAT; pidx = 0; blk = PAT;
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 5000; i++) begin
         c = $urandom_range(0, 2) != 0;
         r = $urandom_range(0, 799) == 0;
         q = $urandom_range(0, 399) == 0;
         t = ($urandom_range(0, 3) != 0) ? train : ~train;
         if (c && pidx == 0) blk = ($urandom_range(0, 9) < 7) ? pw : $urandom;
         d = blk[31 - 4*pidx -: 4];
         if (c && $urandom_range(0, 59) == 0) d = 4'($urandom);
         else if (c) pidx = (pidx + 1) % 8;
         step(r, q, t, c, d);
         if (!r && !q && m_mode == M_IDLE && $urandom_range(0, 19) == 0)
            step(1'b0, 1'b1, train, 1'b0, 4'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
